// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch request/response and decode handshake bundle for pc_fetch_unit
// master = fetch unit side, slave = memory/decode side.
interface pc_fetch_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          fetch_valid;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;

  modport master (
    output fetch_valid, fetch_addr, inst_valid, inst_data, inst_pc,
    input  fetch_ready, rsp_valid, rsp_data, inst_ready
  );

  modport slave (
    input  fetch_valid, fetch_addr, inst_valid, inst_data, inst_pc,
    output fetch_ready, rsp_valid, rsp_data, inst_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC owner and single-outstanding instruction fetcher with redirect
// Optional stall counter output stall_cnt_o enabled by FETCH_STALL_CNT_EN.
module pc_fetch_unit #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(32'h0040_0000),
  parameter int            PC_INC   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena_i,
  input  logic                 redirect_valid_i,
  input  logic [AW-1:0]        redirect_pc_i,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0]          stall_cnt_o,
`endif
  pc_fetch_unit_if.master      bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          drop_q, drop_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic          inst_valid_q, inst_valid_d;
  logic [DW-1:0] inst_data_q, inst_data_d;
  logic [AW-1:0] inst_pc_q, inst_pc_d;
  state_e        resume_state;

  assign resume_state = ena_i ? REQ : IDLE;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    case (state_q)
      IDLE: if (ena_i) state_d = REQ;
      REQ: begin
        if (bus.fetch_ready) begin
          state_d = WAIT;
          // Request left with the old address; its response must be thrown away.
          if (redirect_valid_i) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.rsp_valid) begin
          if (drop_q || redirect_valid_i) begin
            drop_d  = 1'b0;
            state_d = resume_state;
          end else begin
            inst_valid_d = 1'b1;
            inst_data_d  = bus.rsp_data;
            inst_pc_d    = pc_q;
            pc_d         = pc_q + AW'(PC_INC);
            state_d      = HOLD;
          end
        end else if (redirect_valid_i) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid_i || bus.inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = resume_state;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid_i) pc_d = {redirect_pc_i[AW-1:2], 2'b00};
    fetch_valid_d = (state_d == REQ);
    fetch_addr_d  = pc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_addr_q  <= RESET_PC;
      inst_valid_q  <= 1'b0;
      inst_data_q   <= '0;
      inst_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_addr_q  <= fetch_addr_d;
      inst_valid_q  <= inst_valid_d;
      inst_data_q   <= inst_data_d;
      inst_pc_q     <= inst_pc_d;
    end
  end

  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_addr  = fetch_addr_q;
  assign bus.inst_valid  = inst_valid_q;
  assign bus.inst_data   = inst_data_q;
  assign bus.inst_pc     = inst_pc_q;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stalled;

  assign stalled = ((state_q == REQ) && !bus.fetch_ready) ||
                   ((state_q == WAIT) && !bus.rsp_valid);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stalled && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed vector table, corner sequences and randomized scoreboard for pc_fetch_unit
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = '0;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  pc_fetch_unit_if #(.AW(32), .DW(32)) bus ();

  pc_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .ena_i            (ena),
    .redirect_valid_i (redir),
    .redirect_pc_i    (rpc),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt_o      (stall_cnt),
`endif
    .bus              (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ena, frdy, rv;
    logic [31:0] rdata;
    logic        irdy, redir;
    logic [31:0] rpc;
    logic        fv;
    logic [31:0] fa;
    logic        iv;
    logic [31:0] id, ip;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic fr, input logic rv, input logic [31:0] rd,
                     input logic ir, input logic rdr, input logic [31:0] rp,
                     input logic fv, input logic [31:0] fa, input logic iv,
                     input logic [31:0] id, input logic [31:0] ip);
    vec_t v;
    v.ena = e; v.frdy = fr; v.rv = rv; v.rdata = rd; v.irdy = ir; v.redir = rdr; v.rpc = rp;
    v.fv = fv; v.fa = fa; v.iv = iv; v.id = id; v.ip = ip;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic fr, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic rdr, input logic [31:0] rp);
    ena = e; bus.fetch_ready = fr; bus.rsp_valid = rv; bus.rsp_data = rd;
    bus.inst_ready = ir; redir = rdr; rpc = rp;
  endtask

  task automatic chk_outs(input string tag, input logic fv, input logic [31:0] fa,
                          input logic iv, input logic [31:0] id, input logic [31:0] ip);
    chk({tag, ".fetch_valid"}, {31'd0, bus.fetch_valid}, {31'd0, fv});
    chk({tag, ".fetch_addr"}, bus.fetch_addr, fa);
    chk({tag, ".inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, iv});
    chk({tag, ".inst_data"}, bus.inst_data, id);
    chk({tag, ".inst_pc"}, bus.inst_pc, ip);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  localparam logic [31:0] D0 = 32'h2008_0005;

  initial begin
    logic [31:0] exp_pc, paddr, pre_fa, pre_id, pre_ip;
    logic        pending, acc, hold_f, hold_i;
    int          cnt, deliveries;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(); step();
    chk_outs("reset", 1'b0, 32'h0040_0000, 1'b0, 32'h0, 32'h0);
`ifdef FETCH_STALL_CNT_EN
    chk("reset.stall_cnt", stall_cnt, 32'h0);
`endif
    rst = 1'b1;

    add(1,0,0,32'h0,0,0,32'h0,          1,32'h0040_0000,0,32'h0,32'h0);
    add(1,1,0,32'h0,0,0,32'h0,          0,32'h0040_0000,0,32'h0,32'h0);
    add(1,0,1,D0,0,0,32'h0,             0,32'h0040_0004,1,D0,32'h0040_0000);
    for (int i = 0; i < 5; i++)
      add(1,0,0,32'h0,0,0,32'h0,        0,32'h0040_0004,1,D0,32'h0040_0000);
    add(1,0,0,32'h0,1,0,32'h0,          1,32'h0040_0004,0,D0,32'h0040_0000);
    add(1,1,0,32'h0,0,0,32'h0,          0,32'h0040_0004,0,D0,32'h0040_0000);
    add(1,0,0,32'h0,0,1,32'h0040_0103,  0,32'h0040_0100,0,D0,32'h0040_0000);
    add(1,0,1,32'hDEAD_BEEF,0,0,32'h0,  1,32'h0040_0100,0,D0,32'h0040_0000);
    add(1,1,0,32'h0,0,0,32'h0,          0,32'h0040_0100,0,D0,32'h0040_0000);
    add(1,0,1,32'h1234_5678,0,0,32'h0,  0,32'h0040_0104,1,32'h1234_5678,32'h0040_0100);
    add(1,0,0,32'h0,1,1,32'h0040_0200,  1,32'h0040_0200,0,32'h1234_5678,32'h0040_0100);
    add(0,0,0,32'h0,0,0,32'h0,          1,32'h0040_0200,0,32'h1234_5678,32'h0040_0100);
    add(0,1,0,32'h0,0,0,32'h0,          0,32'h0040_0200,0,32'h1234_5678,32'h0040_0100);
    add(0,0,1,32'h0000_AAAA,0,0,32'h0,  0,32'h0040_0204,1,32'h0000_AAAA,32'h0040_0200);
    add(0,0,0,32'h0,1,0,32'h0,          0,32'h0040_0204,0,32'h0000_AAAA,32'h0040_0200);
    add(0,0,0,32'h0,0,0,32'h0,          0,32'h0040_0204,0,32'h0000_AAAA,32'h0040_0200);

    foreach (tbl[i]) begin
      drive(tbl[i].ena, tbl[i].frdy, tbl[i].rv, tbl[i].rdata, tbl[i].irdy, tbl[i].redir, tbl[i].rpc);
      step();
      chk_outs($sformatf("vec%0d", i), tbl[i].fv, tbl[i].fa, tbl[i].iv, tbl[i].id, tbl[i].ip);
    end

    // PC wrap at the top of the address space
    drive(1, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFF);
    step();
    chk("wrap.req_addr", bus.fetch_addr, 32'hFFFF_FFFC);
    drive(1, 1, 0, 32'h0, 0, 0, 32'h0);
    step();
    drive(1, 0, 1, 32'h0BAD_F00D, 0, 0, 32'h0);
    step();
    chk("wrap.inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
    chk("wrap.next_addr", bus.fetch_addr, 32'h0000_0000);
    drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
    step();
    chk("wrap.req_valid", {31'd0, bus.fetch_valid}, 32'd1);
    chk("wrap.req_addr0", bus.fetch_addr, 32'h0000_0000);

    // Stalls then asynchronous reset while a request is outstanding
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    ena = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    bus.fetch_ready = 1'b1; step();
    bus.fetch_ready = 1'b0; step(); step();
    bus.rsp_valid = 1'b1; bus.rsp_data = 32'h5555_AAAA; step();
    bus.rsp_valid = 1'b0; bus.inst_ready = 1'b1; step();
    bus.inst_ready = 1'b0; bus.fetch_ready = 1'b1; step();
    bus.fetch_ready = 1'b0;
    chk_outs("prerst", 1'b0, 32'h0040_0004, 1'b0, 32'h5555_AAAA, 32'h0040_0000);
`ifdef FETCH_STALL_CNT_EN
    chk("prerst.stall_cnt", stall_cnt, 32'd5);
`endif
    rst = 1'b0;
    #1;
    chk_outs("midrst", 1'b0, 32'h0040_0000, 1'b0, 32'h0, 32'h0);
`ifdef FETCH_STALL_CNT_EN
    chk("midrst.stall_cnt", stall_cnt, 32'h0);
`endif
    @(negedge clk) rst = 1'b1;
    step();

    // Randomized traffic against a stream-level model: delivered PCs are consecutive
    // from the last redirect target, and each word matches memory at its PC.
    exp_pc = 32'h0040_0000;
    pending = 1'b0; paddr = '0; cnt = 0; deliveries = 0;
    hold_f = 1'b0; hold_i = 1'b0; pre_fa = '0; pre_id = '0; pre_ip = '0;
    for (int c = 0; c < 4000; c++) begin
      ena = ($urandom_range(0, 9) != 0);
      bus.fetch_ready = ($urandom_range(0, 9) < 7);
      bus.inst_ready = ($urandom_range(0, 9) < 6);
      redir = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      bus.rsp_valid = 1'b0;
      bus.rsp_data = $urandom;
      if (pending) begin
        if (cnt == 0) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_data = memf(paddr);
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (hold_f) begin
        chk("rnd.fetch_hold", {31'd0, bus.fetch_valid}, 32'd1);
        chk("rnd.addr_stable", bus.fetch_addr, pre_fa);
      end
      if (hold_i) begin
        chk("rnd.inst_hold", {31'd0, bus.inst_valid}, 32'd1);
        chk("rnd.data_stable", bus.inst_data, pre_id);
        chk("rnd.pc_stable", bus.inst_pc, pre_ip);
      end
      acc = bus.fetch_valid && bus.fetch_ready;
      pre_fa = bus.fetch_addr; pre_id = bus.inst_data; pre_ip = bus.inst_pc;
      hold_f = bus.fetch_valid && !bus.fetch_ready && !redir;
      hold_i = bus.inst_valid && !bus.inst_ready && !redir;
      if (redir) begin
        exp_pc = {rpc[31:2], 2'b00};
      end else if (bus.inst_valid && bus.inst_ready) begin
        chk("rnd.inst_pc", bus.inst_pc, exp_pc);
        chk("rnd.inst_data", bus.inst_data, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      step();
      if (acc) begin
        pending = 1'b1;
        paddr = pre_fa;
        cnt = $urandom_range(0, 3);
      end
    end
    chk("rnd.deliveries_min", {31'd0, deliveries >= 100}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
